control_unit: RTL and testbench

- Multi-cycle control FSM directly downstream of the instruction register.
- Consumes the 4-bit opcode that the instruction register produces and sequences fetch, decode, execute, memory and PC-update steps.
- Drives the instruction register load enable, the PC, the ALU, the accumulator and the memory request handshake.
- Reports halted, illegal-opcode and bus-timeout status, and maintains a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/control_unit.sv | 159 +++++++++++++++
 tb/tb_control_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: opcodes, ALU operation codes and control states.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Maps an arithmetic/logic opcode to the ALU operation it needs.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles and flags a bus timeout.
module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_count;

    // Count stalled cycles; restart on any state change or completed request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (clear || ready) begin
            wait_count <= '0;
        end else if (active) begin
            wait_count <= wait_count + 8'd1;
        end
    end

    // A ready in the final allowed cycle wins over the timeout.
    assign timeout = active && !ready && (wait_count == LIMIT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM sequencing fetch, decode, execute, memory and PC update.
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [2:0]       alu_op,
    output logic             acc_write,
    output logic             acc_src,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    state_t state;
    state_t next_state;
    logic   retire;
    logic   set_illegal;
    logic   set_bus_error;
    logic   timer_active;
    logic   timer_clear;
    logic   timeout;

    assign timer_active = (state == ST_FETCH) || (state == ST_MEM);
    assign timer_clear  = (next_state != state);
    assign halted       = (state == ST_HALT);
    assign state_dbg    = state;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .active  (timer_active),
        .ready   (mem_ready),
        .clear   (timer_clear),
        .timeout (timeout)
    );

    // Next-state and strobe decode; everything stays quiet while reset is held.
    always_comb begin
        next_state    = state;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        alu_op        = ALU_PASS;
        acc_write     = 1'b0;
        acc_src       = 1'b0;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = ST_DECODE;
                    end else if (timeout) begin
                        set_bus_error = 1'b1;
                        next_state    = ST_HALT;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_NOP: begin
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR: next_state = ST_EXEC;
                        OP_LOAD, OP_STORE:             next_state = ST_MEM;
                        OP_JUMP: begin
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end
                        OP_BEQ: begin
                            pc_write   = zero_flag;
                            pc_src     = 1'b1;
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end
                        OP_HALT: begin
                            retire     = 1'b1;
                            next_state = ST_HALT;
                        end
                        default: begin
                            set_illegal = 1'b1;
                            next_state  = ST_HALT;
                        end
                    endcase
                end
                ST_EXEC: begin
                    alu_op     = alu_sel(opcode);
                    acc_write  = 1'b1;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_STORE);
                    if (mem_ready) begin
                        acc_write  = (opcode == OP_LOAD);
                        acc_src    = (opcode == OP_LOAD);
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end else if (timeout) begin
                        set_bus_error = 1'b1;
                        next_state    = ST_HALT;
                    end
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_FETCH;
            endcase
        end
    end

    // State register, retired-instruction counter and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal_op <= 1'b1;
            end
            if (set_bus_error) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table, hand sequences and random instructions.
module tb_control_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic             ir_write;
        logic             pc_write;
        logic             pc_src;
        logic             mem_req;
        logic             mem_we;
        logic             mem_addr_sel;
        logic [2:0]       alu_op;
        logic             acc_write;
        logic             acc_src;
        logic             halted;
        logic             illegal_op;
        logic             bus_error;
        logic [CNT_W-1:0] retired;
        logic [2:0]       state;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic             clock;
    logic             reset;
    logic [3:0]       opcode;
    logic             zero_flag;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic [2:0]       alu_op;
    logic             acc_write;
    logic             acc_src;
    logic             halted;
    logic             illegal_op;
    logic             bus_error;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_dbg;

    out_t got;

    int   vectors;
    int   miscompares;
    int   expRetired;
    logic expIllegal;
    logic expBusErr;
    logic inHalt;

    control_unit #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .zero_flag    (zero_flag),
        .mem_ready    (mem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_op       (alu_op),
        .acc_write    (acc_write),
        .acc_src      (acc_src),
        .halted       (halted),
        .illegal_op   (illegal_op),
        .bus_error    (bus_error),
        .retired      (retired),
        .state_dbg    (state_dbg)
    );

    assign got = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_op,
                  acc_write, acc_src, halted, illegal_op, bus_error, retired, state_dbg};

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequencing ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t mk(input logic irw, input logic pcw, input logic pcs,
                                input logic mreq, input logic mwe, input logic masel,
                                input logic [2:0] alu, input logic accw, input logic accs,
                                input logic hlt, input logic ill, input logic bus,
                                input logic [CNT_W-1:0] ret, input logic [2:0] st);
        out_t e;
        e = {irw, pcw, pcs, mreq, mwe, masel, alu, accw, accs, hlt, ill, bus, ret, st};
        return e;
    endfunction

    function automatic out_t expBase(input logic [2:0] st);
        out_t e;
        e            = '0;
        e.state      = st;
        e.halted     = (st == 3'd4);
        e.retired    = expRetired[CNT_W-1:0];
        e.illegal_op = expIllegal;
        e.bus_error  = expBusErr;
        return e;
    endfunction

    function automatic logic [2:0] aluCode(input logic [3:0] op);
        case (op)
            4'h3:    return 3'd1;
            4'h4:    return 3'd2;
            4'h5:    return 3'd3;
            4'h6:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic z, input logic rdy);
        @(negedge clock);
        reset     = 1'b0;
        opcode    = op;
        zero_flag = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s (vector %0d): got=%h expected=%h", name, vectors, got, exp);
        end
    endtask

    task automatic cycle(input string name, input logic [3:0] op, input logic z,
                         input logic rdy, input out_t exp);
        applyStimulus(op, z, rdy);
        checkOutput(name, exp);
    endtask

    // Hold reset for a cycle and check the quiet reset outputs; next stimulus releases it.
    task automatic doReset();
        @(negedge clock);
        reset      = 1'b1;
        opcode     = 4'($urandom_range(0, 15));
        zero_flag  = 1'b1;
        mem_ready  = 1'b1;
        expRetired = 0;
        expIllegal = 1'b0;
        expBusErr  = 1'b0;
        inHalt     = 1'b0;
        #1;
        checkOutput("reset", expBase(3'd0));
    endtask

    task automatic runHalt(input int n);
        for (int i = 0; i < n; i++) begin
            cycle("halt_hold", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), expBase(3'd4));
        end
    endtask

    // Instruction-level reference: builds the expected per-cycle trace of one instruction.
    task automatic runInstruction(input logic [3:0] op, input logic z,
                                  input int fetchWait, input int memWait);
        out_t e;
        logic r;
        logic doRetire;
        logic goExec;
        logic goMem;
        logic goHalt;
        for (int i = 0; i <= fetchWait; i++) begin
            r = (i == fetchWait);
            e = expBase(3'd0);
            e.mem_req = 1'b1;
            if (r) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            cycle("fetch", op, 1'($urandom_range(0, 1)), r, e);
            if (!r && i == TIMEOUT - 1) begin
                expBusErr = 1'b1;
                inHalt    = 1'b1;
                return;
            end
        end
        e        = expBase(3'd1);
        doRetire = 1'b0;
        goExec   = 1'b0;
        goMem    = 1'b0;
        goHalt   = 1'b0;
        case (op)
            4'h0: doRetire = 1'b1;
            4'h1, 4'h2: goMem = 1'b1;
            4'h3, 4'h4, 4'h5, 4'h6: goExec = 1'b1;
            4'h7: begin
                e.pc_write = 1'b1;
                e.pc_src   = 1'b1;
                doRetire   = 1'b1;
            end
            4'h8: begin
                e.pc_write = z;
                e.pc_src   = 1'b1;
                doRetire   = 1'b1;
            end
            4'hF: begin
                doRetire = 1'b1;
                goHalt   = 1'b1;
            end
            default: goHalt = 1'b1;
        endcase
        cycle("decode", op, z, 1'($urandom_range(0, 1)), e);
        if (doRetire) expRetired++;
        if (op inside {[4'h9:4'hE]}) expIllegal = 1'b1;
        if (goHalt) begin
            inHalt = 1'b1;
            return;
        end
        if (goExec) begin
            e           = expBase(3'd2);
            e.alu_op    = aluCode(op);
            e.acc_write = 1'b1;
            cycle("exec", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            expRetired++;
        end
        if (goMem) begin
            for (int i = 0; i <= memWait; i++) begin
                r = (i == memWait);
                e = expBase(3'd3);
                e.mem_req      = 1'b1;
                e.mem_addr_sel = 1'b1;
                e.mem_we       = (op == 4'h2);
                if (r && op == 4'h1) begin
                    e.acc_write = 1'b1;
                    e.acc_src   = 1'b1;
                end
                cycle("mem", op, 1'($urandom_range(0, 1)), r, e);
                if (r) begin
                    expRetired++;
                end else if (i == TIMEOUT - 1) begin
                    expBusErr = 1'b1;
                    inHalt    = 1'b1;
                    return;
                end
            end
        end
    endtask

    vec_t tbl[6];

    initial begin
        logic [3:0] op;
        int         sel;
        int         fw;
        int         mw;
        out_t       e;

        vectors     = 0;
        miscompares = 0;
        expRetired  = 0;
        expIllegal  = 1'b0;
        expBusErr   = 1'b0;
        inHalt      = 1'b0;
        reset       = 1'b1;
        opcode      = 4'h0;
        zero_flag   = 1'b0;
        mem_ready   = 1'b0;

        // Two back-to-back ADDs with memory always ready.
        tbl[0] = '{4'h3, 1'b0, 1'b1, mk(1,1,0,1,0,0,3'd0,0,0,0,0,0,4'd0,3'd0)};
        tbl[1] = '{4'h3, 1'b0, 1'b1, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,4'd0,3'd1)};
        tbl[2] = '{4'h3, 1'b0, 1'b1, mk(0,0,0,0,0,0,3'd1,1,0,0,0,0,4'd0,3'd2)};
        tbl[3] = '{4'h3, 1'b1, 1'b1, mk(1,1,0,1,0,0,3'd0,0,0,0,0,0,4'd1,3'd0)};
        tbl[4] = '{4'h3, 1'b1, 1'b1, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,4'd1,3'd1)};
        tbl[5] = '{4'h3, 1'b1, 1'b1, mk(0,0,0,0,0,0,3'd1,1,0,0,0,0,4'd1,3'd2)};

        doReset();
        for (int i = 0; i < 6; i++) begin
            cycle("add_table", tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp);
        end
        expRetired = 2;

        runInstruction(4'h1, 1'b0, 0, 3);
        runInstruction(4'h2, 1'b1, 1, 3);
        runInstruction(4'h8, 1'b1, 0, 0);
        runInstruction(4'h8, 1'b0, 0, 0);
        runInstruction(4'h7, 1'b0, 2, 0);
        runInstruction(4'h6, 1'b0, 0, 0);
        runInstruction(4'h4, 1'b1, 0, 0);
        runInstruction(4'h5, 1'b0, 0, 0);
        runInstruction(4'h3, 1'b0, TIMEOUT - 1, 0);
        for (int i = 0; i < 18; i++) begin
            runInstruction(4'h0, 1'($urandom_range(0, 1)), 0, 0);
        end

        // Reset lands in the middle of a stalled LOAD.
        e = expBase(3'd0);
        e.mem_req  = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        cycle("mid_fetch", 4'h1, 1'b0, 1'b1, e);
        cycle("mid_decode", 4'h1, 1'b0, 1'b0, expBase(3'd1));
        e = expBase(3'd3);
        e.mem_req      = 1'b1;
        e.mem_addr_sel = 1'b1;
        cycle("mid_mem", 4'h1, 1'b0, 1'b0, e);
        #1;
        reset      = 1'b1;
        expRetired = 0;
        #1;
        checkOutput("reset_mid_mem", expBase(3'd0));
        runInstruction(4'h3, 1'b0, 0, 0);

        runInstruction(4'hA, 1'b0, 0, 0);
        runHalt(4);
        doReset();
        runInstruction(4'h0, 1'b0, 10, 0);
        runHalt(3);
        doReset();
        runInstruction(4'h1, 1'b0, 0, 6);
        runHalt(2);
        doReset();
        runInstruction(4'hF, 1'b0, 0, 0);
        runHalt(2);
        doReset();

        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       op = 4'($urandom_range(0, 8));
            else if (sel == 8) op = 4'hF;
            else               op = 4'($urandom_range(9, 14));
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(TIMEOUT, TIMEOUT + 2);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(TIMEOUT, TIMEOUT + 2);
            runInstruction(op, 1'($urandom_range(0, 1)), fw, mw);
            if (inHalt) begin
                runHalt(2);
                doReset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
